adc_spi_responder: RTL and testbench
====================================

# adc_spi_responder

- FPGA-side emulator of the 8-channel, 12-bit serial ADC on the `adc_cs`/`adc_sclk`/`adc_din`/`adc_dout` pins.
- Sits on the device end of the serial link: it takes chip-select, serial clock and command bits from the ADC controller and returns 16-bit sample frames.
- Used for hardware loopback and simulation of the scope's acquisition path. Channel samples are loaded from the fabric, so waveform tests are deterministic.
- Reproduces the real part's control-word decoding, one-frame address pipelining and output coding.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `adc_cs`, `adc_sclk` and `adc_din`. Must be ≥ 2.
- `NUM_CH`, default 8: number of channels. Fixed at 8, because the address field is 3 bits.
- `DATA_W`, default 12: sample width. Fixed at 12.

Ports:
- `clk`, in, 1: the block's only clock. Must be at least 8× the `adc_sclk` frequency.
- `reset`, in, 1: synchronous, active-high reset.
- `adc_cs`, in, 1: chip select, active low. Asynchronous to `clk`.
- `adc_sclk`, in, 1: serial clock from the controller. Idles high.
- `adc_din`, in, 1: command bits, MSB first.
- `adc_dout`, out, 1: frame data, MSB first.
- `wr_en`, in, 1: sample-register write strobe.
- `wr_addr`, in, 3: channel to write.
- `wr_data`, in, 12: sample value, straight binary.
- `ctrl_word`, out, 12: last committed control word.
- `cur_addr`, out, 3: channel that will be returned in the next frame.
- `frame_done`, out, 1: one-cycle pulse when a frame completes with all 16 falling edges.
- `frame_abort`, out, 1: one-cycle pulse when `adc_cs` rises before 16 falling edges.

## Operation
Input conditioning:
- `adc_cs`, `adc_sclk` and `adc_din` each pass through `SYNC_STAGES` flops.
- Edge detectors run on the synchronized `adc_cs` (falling and rising) and `adc_sclk` (falling).
- Synchronizer flops for `adc_cs` reset to 0. This prevents a false CS falling edge if `adc_cs` is already low when reset releases.

Control word, 12 bits, MSB first:
- Bit 11 WRITE, bit 10 SEQ, bit 9 don't-care.
- Bits 8:6 ADD.
- Bits 5:4 PM, bit 3 SHADOW, bit 2 don't-care.
- Bit 1 RANGE, bit 0 CODING.
- DIN bits 3:0 of the 16-bit frame are ignored.
- SEQ, SHADOW, PM and RANGE are stored in `ctrl_word` but have no other effect.

Output frame, 16 bits, MSB first:
- Bit 15 is 0.
- Bits 14:12 are the address of the channel being returned.
- Bits 11:0 are the sample after coding.

Coding:
- CODING=1: sample is sent unchanged (straight binary).
- CODING=0: sample is sent as `sample ^ 12'h800` (two's complement).

Frame flow:
- On CS falling edge, latch `{1'b0, cur_addr, coded(sample[cur_addr])}` into a 16-bit shift register. Coding uses the current `ctrl_word[0]`.
- Writes to the sample registers during a frame do not affect the latched frame.
- `wr_en` writes `wr_data` to `sample[wr_addr]` on any cycle.

FSM states:
- IDLE: `adc_dout` = 0. A CS falling edge loads the shift register and moves to SHIFT.
- SHIFT, on each SCLK falling edge: sample synchronized DIN into `din_sr`, shift `dout_sr` left by 1, increment the 4-bit `bit_cnt`.
- SHIFT, on the 16th falling edge: if `din_sr[15]` (WRITE) is 1, commit `ctrl_word` ← `din_sr[15:4]` and `cur_addr` ← ADD. Pulse `frame_done` and move to DONE.
- SHIFT, on CS rising edge before the 16th falling edge: pulse `frame_abort`, make no control update, return to IDLE.
- DONE: `adc_dout` = 0. Extra SCLK edges are ignored. A CS rising edge returns to IDLE.
- `adc_dout` = `dout_sr[15]` in SHIFT, otherwise 0.

Address pipelining: the frame that writes ADD=n returns the previous channel. The following frame returns channel n.

## Timing
Reset values:
- `adc_dout`=0, `frame_done`=0, `frame_abort`=0.
- `ctrl_word`=12'h001 (CODING=1), `cur_addr`=0.
- All sample registers 0, FSM in IDLE.

Latencies:
- `adc_dout` presents bit 15 no later than `SYNC_STAGES`+2 `clk` cycles after pin CS falls.
- Each later bit appears within `SYNC_STAGES`+2 cycles of the pin SCLK falling edge. The controller samples on the falling edge, which lies before this update.
- `ctrl_word`, `cur_addr` and `frame_done` update in the same cycle as the 16th detected falling edge.

Boundary conditions:
- A CS rising edge and the 16th SCLK falling edge in the same cycle count as a completed frame: `frame_done` pulses, `frame_abort` does not.
- A `wr_en` to channel `cur_addr` in the same cycle as a CS falling edge: the frame carries the old value.
- Reset asserted mid-frame returns all outputs to their reset values with no pulse.
- After reset, a new frame requires `adc_cs` to go high and then fall.

## Structure
- Package `adc_pkg` holds:
  - `FRAME_BITS`=16, `CTRL_BITS`=12;
  - the control-field bit positions;
  - the FSM state enum `{IDLE, SHIFT, DONE}`;
  - the coding function.
- Sub-module `sync_edge`: a `SYNC_STAGES`-deep synchronizer with rise/fall pulses and a parameterized reset value. It is instantiated 3×.

## Test plan
- **Address pipelining:** preload ch0=0x123 and ch3=0xABC, then send frame DIN=0x8F10. DOUT=0x0123, `cur_addr`=3, `ctrl_word`=0x8F1. Next frame with DIN=0x0000: DOUT=0x3ABC and `ctrl_word` unchanged.
- **Two's-complement coding:** after ADD=3, send DIN=0x8F00 (CODING=0). The following frame returns DOUT=0x32BC.
- **Abort:** raise CS after 7 SCLK falling edges with DIN=0xFFFF. `frame_abort` pulses once, no `frame_done`, `ctrl_word` and `cur_addr` unchanged, `adc_dout`=0.
- **Write during frame:** write ch3=0x555 at edge 5 of a frame returning ch3. This frame returns 0x3ABC; the next returns 0x3555.
- **Reset mid-frame:** assert `reset` at edge 8 while CS is held low. Outputs take their reset values and no pulse occurs. Extra edges are ignored until CS goes high; the next frame returns 0x0000.
- **Over-clocked frame:** send 20 SCLK edges in one frame. Exactly one `frame_done` at edge 16, and `adc_dout`=0 for edges 17–20.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants, control-word field positions, FSM states and output coding
// for the serial ADC responder.
package adc_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int CTRL_BITS   = 12;

  localparam int CTRL_WRITE  = 11;
  localparam int CTRL_SEQ    = 10;
  localparam int CTRL_ADD_HI = 8;
  localparam int CTRL_ADD_LO = 6;
  localparam int CTRL_PM_HI  = 5;
  localparam int CTRL_PM_LO  = 4;
  localparam int CTRL_SHADOW = 3;
  localparam int CTRL_RANGE  = 1;
  localparam int CTRL_CODING = 0;

  localparam logic [CTRL_BITS-1:0] CTRL_RESET = 12'h001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // CODING=1 sends straight binary, CODING=0 flips the MSB for two's complement.
  function automatic logic [11:0] code_sample(input logic [11:0] sample, input logic coding);
    return coding ? sample : (sample ^ 12'h800);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle rise and
// fall pulses derived from the synchronized level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= {STAGES{RST_VAL}};
      r_prev  <= RST_VAL;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = r_chain[STAGES-1] & ~r_prev;
  assign o_fall = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/adc_spi_responder.sv
// Device-side emulator of an 8-channel 12-bit serial ADC: decodes the control
// word, pipelines the channel address by one frame and returns coded samples.
module adc_spi_responder
  import adc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_cs,
  input  logic              adc_sclk,
  input  logic              adc_din,
  output logic              adc_dout,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [11:0]       ctrl_word,
  output logic [2:0]        cur_addr,
  output logic              frame_done,
  output logic              frame_abort,
  output logic [1:0]        dbg_state
);

  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_din_sync, w_din_rise, w_din_fall;

  // CS flops reset low so a pin already low at reset release is not seen as a fall.
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .reset(reset), .i_async(adc_cs),
    .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .reset(reset), .i_async(adc_sclk),
    .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
    .clk(clk), .reset(reset), .i_async(adc_din),
    .o_sync(w_din_sync), .o_rise(w_din_rise), .o_fall(w_din_fall)
  );

  state_t                r_state, w_state_next;
  logic [DATA_W-1:0]     r_sample [NUM_CH];
  logic [CTRL_BITS-1:0]  r_ctrl;
  logic [2:0]            r_cur_addr;
  logic [FRAME_BITS-1:0] r_dout_sr;
  logic [14:0]           r_din_sr;
  logic [3:0]            r_bit_cnt;
  logic                  r_frame_done;
  logic                  r_frame_abort;
  logic                  w_done;
  logic                  w_abort;
  logic [FRAME_BITS-1:0] w_din_next;
  logic [CTRL_BITS-1:0]  w_ctrl_next;
  logic                  w_unused;

  // Word as it will stand once the current falling edge has shifted in.
  assign w_din_next  = {r_din_sr, w_din_sync};
  assign w_ctrl_next = w_din_next[FRAME_BITS-1:FRAME_BITS-CTRL_BITS];
  assign w_unused    = &{1'b0, w_cs_sync, w_sclk_sync, w_sclk_rise,
                         w_din_rise, w_din_fall, w_din_next[3:0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // A CS rise in the same cycle as the 16th fall still completes the frame.
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE:  if (w_cs_fall) w_state_next = SHIFT;
      SHIFT: begin
        if (w_sclk_fall && (r_bit_cnt == 4'd15)) begin
          w_done       = 1'b1;
          w_state_next = w_cs_rise ? IDLE : DONE;
        end else if (w_cs_rise) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
      end
      DONE:  if (w_cs_rise) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    adc_dout = 1'b0;
    if (r_state == SHIFT) adc_dout = r_dout_sr[FRAME_BITS-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) r_sample[i] <= '0;
      r_ctrl        <= CTRL_RESET;
      r_cur_addr    <= 3'd0;
      r_dout_sr     <= '0;
      r_din_sr      <= '0;
      r_bit_cnt     <= 4'd0;
      r_frame_done  <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_frame_done  <= w_done;
      r_frame_abort <= w_abort;
      if (wr_en) r_sample[wr_addr] <= wr_data;
      if ((r_state == IDLE) && w_cs_fall) begin
        r_dout_sr <= {1'b0, r_cur_addr, code_sample(r_sample[r_cur_addr], r_ctrl[CTRL_CODING])};
        r_bit_cnt <= 4'd0;
      end else if ((r_state == SHIFT) && w_sclk_fall) begin
        r_din_sr  <= w_din_next[14:0];
        r_dout_sr <= {r_dout_sr[FRAME_BITS-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_done && w_ctrl_next[CTRL_WRITE]) begin
        r_ctrl     <= w_ctrl_next;
        r_cur_addr <= w_ctrl_next[CTRL_ADD_HI:CTRL_ADD_LO];
      end
    end
  end

  assign ctrl_word   = r_ctrl;
  assign cur_addr    = r_cur_addr;
  assign frame_done  = r_frame_done;
  assign frame_abort = r_frame_abort;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: directed frames from the test plan plus random
// frames, scored against a channel/control-word model of the real ADC.
module tb_adc_spi_responder;
  import adc_pkg::*;

  localparam int SYNC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        adc_cs = 1'b1;
  logic        adc_sclk = 1'b1;
  logic        adc_din = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [11:0] wr_data = 12'd0;
  logic        adc_dout;
  logic [11:0] ctrl_word;
  logic [2:0]  cur_addr;
  logic        frame_done;
  logic        frame_abort;
  logic [1:0]  dbg_state;

  adc_spi_responder #(.SYNC_STAGES(SYNC), .NUM_CH(8), .DATA_W(12)) dut (
    .clk(clk), .reset(reset),
    .adc_cs(adc_cs), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ctrl_word(ctrl_word), .cur_addr(cur_addr),
    .frame_done(frame_done), .frame_abort(frame_abort), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] dout;   // frame the device should return
    logic [4:0]  nchk;   // leading bits that carry the frame, the rest must be 0
    logic        done;
    logic        abort;
    logic [11:0] ctrl;
    logic [2:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [11:0] m_sample [8];
  logic [11:0] m_ctrl;
  logic [2:0]  m_addr;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_sample[i] = 12'd0;
    m_ctrl = 12'h001;
    m_addr = 3'd0;
  endtask

  int tot_done = 0;
  int tot_abort = 0;
  always @(posedge clk) begin
    if (frame_done === 1'b1) tot_done++;
    if (frame_abort === 1'b1) tot_abort++;
  end

  // ---------------- driver tasks ----------------
  task automatic write_ch(input logic [2:0] ch, input logic [11:0] v);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = ch; wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
    m_sample[ch] = v;
  endtask

  task automatic send_frame(input logic [15:0] din, input int nedges,
                            input int wr_edge, input logic [2:0] wr_ch, input logic [11:0] wr_val,
                            input bit wr_at_fall, input bit cs_with_last, input int reset_at);
    exp_t e;
    logic [11:0] s;
    s = m_sample[m_addr];
    e.dout  = {1'b0, m_addr, m_ctrl[0] ? s : (s ^ 12'h800)};
    e.nchk  = 5'((nedges < 16) ? nedges : 16);
    e.done  = 1'b0;
    e.abort = 1'b0;
    if (reset_at >= 0) begin
      e.nchk = 5'(reset_at);
      model_reset();
    end else if (nedges >= 16) begin
      e.done = 1'b1;
      if (din[15]) begin
        m_ctrl = din[15:4];
        m_addr = din[12:10];
      end
    end else begin
      e.abort = 1'b1;
    end
    e.ctrl = m_ctrl;
    e.addr = m_addr;
    exp_q.push_back(e);

    @(negedge clk);
    adc_cs = 1'b0;
    if (wr_at_fall) begin
      repeat (SYNC) @(negedge clk);
      wr_en = 1'b1; wr_addr = wr_ch; wr_data = wr_val;
      @(negedge clk);
      wr_en = 1'b0;
      m_sample[wr_ch] = wr_val;
      repeat (3) @(negedge clk);
    end else begin
      repeat (SYNC + 4) @(negedge clk);
    end

    for (int i = 0; i < nedges; i++) begin
      adc_din = (i < 16) ? din[15 - i] : 1'b0;
      repeat (2) @(negedge clk);
      adc_sclk = 1'b0;
      if (cs_with_last && (i == nedges - 1)) adc_cs = 1'b1;
      repeat (4) @(negedge clk);
      adc_sclk = 1'b1;
      repeat (2) @(negedge clk);
      if (i + 1 == wr_edge) begin
        wr_en = 1'b1; wr_addr = wr_ch; wr_data = wr_val;
        @(negedge clk);
        wr_en = 1'b0;
        m_sample[wr_ch] = wr_val;
      end
      if (i + 1 == reset_at) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_dout", 32'(adc_dout), 32'd0);
        check("midrst_ctrl", 32'(ctrl_word), 32'h001);
        check("midrst_addr", 32'(cur_addr), 32'd0);
        check("midrst_pulses", 32'({frame_done, frame_abort}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
      end
    end
    if (!cs_with_last) begin
      repeat (2) @(negedge clk);
      adc_cs = 1'b1;
    end
    repeat (14) @(negedge clk);
  endtask

  task automatic frame16(input logic [15:0] din);
    send_frame(din, 16, -1, 3'd0, 12'd0, 1'b0, 1'b0, -1);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [23:0] cap;
    logic [23:0] expv;
    int   n;
    int   d0;
    int   a0;
    bit   prev;
    exp_t e;
    forever begin
      @(negedge adc_cs);
      d0 = tot_done; a0 = tot_abort; n = 0; cap = '0; prev = adc_sclk;
      while (1) begin
        @(adc_sclk or adc_cs);
        if (prev && !adc_sclk) begin
          cap = {cap[22:0], adc_dout};
          n++;
        end
        prev = adc_sclk;
        if (adc_cs) break;
      end
      repeat (8) @(posedge clk);
      #1;
      check("scoreboard_pop", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        expv = '0;
        for (int i = 0; i < n; i++)
          expv = {expv[22:0], (i < int'(e.nchk)) ? e.dout[15 - i] : 1'b0};
        check("dout_bits", 32'(cap), 32'(expv));
        check("frame_done_cnt", 32'(tot_done - d0), 32'(e.done));
        check("frame_abort_cnt", 32'(tot_abort - a0), 32'(e.abort));
        check("ctrl_word", 32'(ctrl_word), 32'(e.ctrl));
        check("cur_addr", 32'(cur_addr), 32'(e.addr));
        check("dout_idle", 32'(adc_dout), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_dout", 32'(adc_dout), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_abort", 32'(frame_abort), 32'd0);
    check("rst_ctrl", 32'(ctrl_word), 32'h001);
    check("rst_addr", 32'(cur_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // address pipelining and coding
    write_ch(3'd0, 12'h123);
    write_ch(3'd3, 12'hABC);
    frame16(16'h8F10);
    frame16(16'h0000);
    frame16(16'h8F00);
    frame16(16'h0000);
    frame16(16'h8F10);
    // abort after 7 edges
    send_frame(16'hFFFF, 7, -1, 3'd0, 12'd0, 1'b0, 1'b0, -1);
    // write during frame, then write in the CS-fall cycle
    send_frame(16'h0000, 16, 5, 3'd3, 12'h555, 1'b0, 1'b0, -1);
    frame16(16'h0000);
    send_frame(16'h0000, 16, -1, 3'd3, 12'h777, 1'b1, 1'b0, -1);
    frame16(16'h0000);
    // CS rise coinciding with the 16th falling edge
    send_frame(16'h8010, 16, -1, 3'd0, 12'd0, 1'b0, 1'b1, -1);
    // reset mid-frame, then a clean frame
    send_frame(16'hFFFF, 12, -1, 3'd0, 12'd0, 1'b0, 1'b0, 8);
    frame16(16'h0000);
    // over-clocked frame
    write_ch(3'd0, 12'hFED);
    send_frame(16'h0000, 20, -1, 3'd0, 12'd0, 1'b0, 1'b0, -1);

    // random frames
    for (int k = 0; k < 30; k++) begin
      int nw;
      int ne;
      int we;
      nw = $urandom_range(0, 2);
      for (int j = 0; j < nw; j++) write_ch(3'($urandom_range(0, 7)), 12'($urandom));
      ne = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : 16;
      we = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : -1;
      send_frame(16'($urandom), ne, we, 3'($urandom_range(0, 7)), 12'($urandom),
                 1'b0, ($urandom_range(0, 5) == 0) && (ne == 16), -1);
    end

    for (int i = 0; (i < 200) && (exp_q.size() != 0); i++) @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
